// File: rtl/bcd_conv_pkg.sv
// Shared types and helpers for the binary-to-BCD converter.
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Digits needed for a wid-bit value, rounded up to a whole digit.
  function automatic int unsigned bcd_width(input int unsigned wid);
    return ((wid + (wid - 32'd4) / 32'd3) + 32'd3) & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_dabble_row.sv
// One double-dabble row: add 3 to every digit >= 5, then shift one operand bit in.
module bcd_dabble_row
  import bcd_conv_pkg::*;
#(
  parameter int unsigned BCDWID = 20
) (
  input  logic [BCDWID-1:0] digits,
  input  logic              shift_in,
  output logic [BCDWID-1:0] result
);

  localparam int unsigned NDIG = BCDWID / 4;

  logic [BCDWID-1:0] adj;
  logic              unused_msb;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    assign adj[4*i +: 4] = add3(digits[4*i +: 4]);
  end

  // The top bit never carries for a correctly sized accumulator.
  assign result     = {adj[BCDWID-2:0], shift_in};
  assign unused_msb = adj[BCDWID-1];

endmodule

// File: rtl/bin_bcd_convert.sv
// Multi-cycle binary-to-BCD converter: integer (double dabble) or fraction
// (repeated x10 with optional round-half-up on a guard digit).
module bin_bcd_convert
  import bcd_conv_pkg::*;
#(
  parameter  int unsigned WID    = 128,
  parameter  int unsigned DEP    = 2,
  parameter  int unsigned DPC    = 2,
  localparam int unsigned BCDWID = bcd_width(WID),
  localparam int unsigned NDIG   = BCDWID / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WID-1:0]    in_bin,
  input  logic              in_frac,
  input  logic              in_rnd,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BCDWID-1:0] out_bcd,
  output logic              out_frac,
  output logic              busy
);

  localparam int unsigned ACCW     = BCDWID + 4;
  localparam int unsigned CNT_INT  = WID / DEP;
  localparam int unsigned CNT_FRAC = (NDIG + 1) / DPC;
  localparam int unsigned CNTW     = $clog2(WID + 1);

  if (DEP == 0 || DPC == 0 || (WID % DEP) != 0 || ((NDIG + 1) % DPC) != 0) begin : g_param_err
    $error("bin_bcd_convert: illegal WID/DEP/DPC combination");
  end

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [WID-1:0]    opnd_q, opnd_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic              frac_q, frac_d;
  logic              rnd_q, rnd_d;
  logic [BCDWID-1:0] bcd_q, bcd_d;
  logic              ofrac_q, ofrac_d;

  assign in_ready  = (state_q == IDLE) & ~abort & ~rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = bcd_q;
  assign out_frac  = ofrac_q;

  // Integer mode: DEP cascaded dabble rows, MSB-first operand bits.
  logic [BCDWID-1:0] row_v [DEP+1];
  assign row_v[0] = acc_q[BCDWID-1:0];

  for (genvar k = 0; k < DEP; k++) begin : g_row
    bcd_dabble_row #(.BCDWID(BCDWID)) u_row (
      .digits   (row_v[k]),
      .shift_in (opnd_q[WID-1-k]),
      .result   (row_v[k+1])
    );
  end

  // Fraction mode: DPC cascaded x10 stages; the integer part of each product is a digit.
  logic [WID-1:0]  frac_f;
  logic [WID+3:0]  frac_p;
  logic [ACCW-1:0] frac_acc;

  always_comb begin
    frac_f   = opnd_q;
    frac_p   = '0;
    frac_acc = acc_q;
    for (int s = 0; s < DPC; s++) begin
      frac_p   = ({4'b0000, frac_f} << 3) + ({4'b0000, frac_f} << 1);
      frac_f   = frac_p[WID-1:0];
      frac_acc = {frac_acc[ACCW-5:0], frac_p[WID+3:WID]};
    end
  end

  // Round half up on the guard digit with decimal carry through all result digits.
  logic [BCDWID-1:0] rnd_bcd;
  logic              rnd_c;
  logic [3:0]        rnd_dig;

  always_comb begin
    rnd_bcd = acc_q[ACCW-1:4];
    rnd_c   = rnd_q && (acc_q[3:0] >= 4'd5);
    rnd_dig = '0;
    for (int i = 0; i < NDIG; i++) begin
      rnd_dig = rnd_bcd[4*i +: 4];
      if (rnd_c) begin
        if (rnd_dig == 4'd9) begin
          rnd_bcd[4*i +: 4] = 4'd0;
        end else begin
          rnd_bcd[4*i +: 4] = rnd_dig + 4'd1;
          rnd_c             = 1'b0;
        end
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    frac_d  = frac_q;
    rnd_d   = rnd_q;
    bcd_d   = bcd_q;
    ofrac_d = ofrac_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          opnd_d  = in_bin;
          frac_d  = in_frac;
          rnd_d   = in_rnd;
          acc_d   = '0;
          cnt_d   = in_frac ? CNTW'(CNT_FRAC) : CNTW'(CNT_INT);
          state_d = CONV;
        end
      end
      CONV: begin
        cnt_d = cnt_q - CNTW'(1);
        if (frac_q) begin
          opnd_d = frac_f;
          acc_d  = frac_acc;
        end else begin
          opnd_d = opnd_q << DEP;
          acc_d  = {4'b0000, row_v[DEP]};
        end
        if (cnt_q == CNTW'(1)) begin
          if (frac_q) begin
            state_d = ROUND;
          end else begin
            bcd_d   = row_v[DEP];
            ofrac_d = 1'b0;
            state_d = DONE;
          end
        end
      end
      ROUND: begin
        bcd_d   = rnd_bcd;
        ofrac_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      frac_q  <= 1'b0;
      rnd_q   <= 1'b0;
      bcd_q   <= '0;
      ofrac_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      frac_q  <= frac_d;
      rnd_q   <= rnd_d;
      bcd_q   <= bcd_d;
      ofrac_q <= ofrac_d;
    end
  end

endmodule

// File: tb/tb_bin_bcd_convert.sv
// Directed bench for bin_bcd_convert: WID=16 and WID=8 instances, vector table plus
// hand sequences for back-pressure, abort and reset.
module tb_bin_bcd_convert;
  import bcd_conv_pkg::*;

  logic        clk, rst, abort, out_ready, in_frac, in_rnd;
  logic        in_valid16, in_valid8;
  logic [15:0] in_bin16;
  logic [7:0]  in_bin8;
  logic        in_ready16, in_ready8, out_valid16, out_valid8;
  logic        out_frac16, out_frac8, busy16, busy8;
  logic [19:0] out_bcd16;
  logic [11:0] out_bcd8;
  int          passed, total;

  typedef struct {
    logic        w8;
    logic        frac;
    logic        rnd;
    logic [15:0] bin;
    logic [19:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [19];

  bin_bcd_convert #(.WID(16), .DEP(2), .DPC(2)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_bin(in_bin16), .in_frac(in_frac), .in_rnd(in_rnd), .abort(abort),
    .out_valid(out_valid16), .out_ready(out_ready), .out_bcd(out_bcd16),
    .out_frac(out_frac16), .busy(busy16)
  );

  bin_bcd_convert #(.WID(8), .DEP(2), .DPC(2)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_bin(in_bin8), .in_frac(in_frac), .in_rnd(in_rnd), .abort(abort),
    .out_valid(out_valid8), .out_ready(out_ready), .out_bcd(out_bcd8),
    .out_frac(out_frac8), .busy(busy8)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Rounding must never carry out of the most significant digit.
  always @(negedge clk) begin
    if (!rst && u16.state_q == ROUND)
      assert (!u16.rnd_c) else $error("FAIL msd_carry16: carry out of most significant digit");
    if (!rst && u8.state_q == ROUND)
      assert (!u8.rnd_c) else $error("FAIL msd_carry8: carry out of most significant digit");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    int          n;
    int          lat;
    logic        rdy;
    logic [19:0] got;
    logic        gfrac;
    lat = v.w8 ? (v.frac ? 3 : 4) : (v.frac ? 4 : 8);
    @(negedge clk);
    in_frac = v.frac;
    in_rnd  = v.rnd;
    if (v.w8) begin
      in_bin8   = v.bin[7:0];
      in_valid8 = 1'b1;
    end else begin
      in_bin16   = v.bin;
      in_valid16 = 1'b1;
    end
    #1;
    rdy = v.w8 ? in_ready8 : in_ready16;
    chk({v.name, "_in_ready"}, 32'(rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid8  = 1'b0;
    in_valid16 = 1'b0;
    n = 0;
    while (!(v.w8 ? out_valid8 : out_valid16) && n < 100) begin
      @(negedge clk);
      n++;
    end
    got   = v.w8 ? 20'(out_bcd8) : out_bcd16;
    gfrac = v.w8 ? out_frac8 : out_frac16;
    chk({v.name, "_latency"}, 32'(n), 32'(lat));
    chk({v.name, "_bcd"}, 32'(got), 32'(v.exp));
    chk({v.name, "_frac"}, 32'(gfrac), 32'(v.frac));
  endtask

  task automatic start16(input logic frac, input logic rnd, input logic [15:0] bin);
    @(negedge clk);
    in_frac    = frac;
    in_rnd     = rnd;
    in_bin16   = bin;
    in_valid16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
  endtask

  initial begin
    int          n;
    logic [19:0] hold;
    logic        ok;

    clk = 1'b0; rst = 1'b1; abort = 1'b0; out_ready = 1'b1;
    in_frac = 1'b0; in_rnd = 1'b0; in_valid16 = 1'b0; in_valid8 = 1'b0;
    in_bin16 = '0; in_bin8 = '0; passed = 0; total = 0;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 20'h65535, "int_ffff"};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 20'h00000, "int_zero"};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h04D2, 20'h01234, "int_1234"};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h2710, 20'h10000, "int_10000"};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'hEA5F, 20'h59999, "int_59999"};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h8000, 20'h50000, "frac_half"};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0001, 20'h00001, "frac_lsb_trunc"};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'h0001, 20'h00002, "frac_lsb_round"};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'hC000, 20'h75000, "frac_three_q"};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 20'h99998, "frac_max_trunc"};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 20'h99998, "frac_max_round"};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h199A, 20'h10000, "frac_tenth_trunc"};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 16'h0017, 20'h00090, "w8_frac23_round"};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 16'h0017, 20'h00089, "w8_frac23_trunc"};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 16'h00FF, 20'h00255, "w8_int255"};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 16'h0064, 20'h00100, "w8_int100"};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 16'h00FF, 20'h00996, "w8_frac_max"};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 16'h199A, 20'h10001, "post_abort_frac"};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 16'h270F, 20'h09999, "post_reset_int"};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid16), 32'd0);
    chk("rst_in_ready", 32'(in_ready16), 32'd0);
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_out_bcd", 32'(out_bcd16), 32'd0);
    chk("rst_out_frac", 32'(out_frac16), 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    // Back-pressure: result held while out_ready is low.
    out_ready = 1'b0;
    start16(1'b0, 1'b0, 16'hFFFF);
    n = 0;
    while (!out_valid16 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 32'(out_valid16), 32'd1);
    hold = out_bcd16;
    ok   = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_bcd16 !== hold || in_ready16 !== 1'b0 || busy16 !== 1'b1 || out_valid16 !== 1'b1)
        ok = 1'b0;
    end
    chk("bp_hold_stable", 32'(ok), 32'd1);
    chk("bp_bcd", 32'(out_bcd16), 32'h65535);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid16), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready16), 32'd1);

    // Abort in the third CONV cycle.
    start16(1'b0, 1'b0, 16'hFFFF);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("abort_busy_before", 32'(busy16), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready16), 32'd1);
    chk("abort_busy_after", 32'(busy16), 32'd0);
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid16 !== 1'b0) ok = 1'b0;
    end
    chk("abort_no_result", 32'(ok), 32'd1);

    // Abort in IDLE blocks a simultaneous request.
    @(negedge clk);
    abort = 1'b1; in_frac = 1'b0; in_bin16 = 16'd42; in_valid16 = 1'b1;
    #1;
    chk("abort_idle_in_ready", 32'(in_ready16), 32'd0);
    @(negedge clk);
    in_valid16 = 1'b0; abort = 1'b0;
    #1;
    chk("abort_idle_not_accepted", 32'(busy16), 32'd0);
    run_vec(vecs[17]);

    // Reset while in ROUND discards the conversion and clears outputs.
    start16(1'b1, 1'b1, 16'h0001);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_in_round", 32'(busy16 && !out_valid16), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid16), 32'd0);
    chk("mid_rst_busy", 32'(busy16), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready16), 32'd0);
    chk("mid_rst_out_bcd", 32'(out_bcd16), 32'd0);
    chk("mid_rst_out_frac", 32'(out_frac16), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready16), 32'd1);
    run_vec(vecs[18]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
